// File: rtl/wb_initiator_pkg.sv
// Shared types and Wishbone widths for the single-transfer initiator and its
// peripheral-side neighbours (wb_mux, wb_memory).
package wb_initiator_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // One latched bus request: everything driven onto io_wbs_* for a cycle.
  typedef struct packed {
    logic              we;
    logic [SEL_W-1:0]  sel;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat;
  } wb_req_t;

endpackage

// File: rtl/wb_initiator_if.sv
// Command/response streams plus the Wishbone classic bus of one initiator.
// The master modport is the initiator's view; slave is the opposite side.
interface wb_initiator_if;
  import wb_initiator_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [SEL_W-1:0]  cmd_sel;
  logic [ADDR_W-1:0] cmd_adr;
  logic [DATA_W-1:0] cmd_dat;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_dat;
  logic              rsp_err;

  logic [ADDR_W-1:0] io_wbs_adr;
  logic [DATA_W-1:0] io_wbs_datwr;
  logic [DATA_W-1:0] io_wbs_datrd;
  logic              io_wbs_we;
  logic [SEL_W-1:0]  io_wbs_sel;
  logic              io_wbs_stb;
  logic              io_wbs_cyc;
  logic              io_wbs_ack;

  modport master (
    input  cmd_valid, cmd_we, cmd_sel, cmd_adr, cmd_dat,
    output cmd_ready,
    output rsp_valid, rsp_dat, rsp_err,
    input  rsp_ready,
    output io_wbs_adr, io_wbs_datwr, io_wbs_we, io_wbs_sel, io_wbs_stb, io_wbs_cyc,
    input  io_wbs_datrd, io_wbs_ack
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_sel, cmd_adr, cmd_dat,
    input  cmd_ready,
    input  rsp_valid, rsp_dat, rsp_err,
    output rsp_ready,
    input  io_wbs_adr, io_wbs_datwr, io_wbs_we, io_wbs_sel, io_wbs_stb, io_wbs_cyc,
    output io_wbs_datrd, io_wbs_ack
  );

endinterface

// File: rtl/wb_timeout_counter.sv
// Saturating bus-cycle counter. expired is high while the count sits at
// TIMEOUT-1, i.e. during the last cycle a slave is allowed to ack in.
module wb_timeout_counter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // TIMEOUT = 1 would give a zero-width counter; keep at least one bit.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q;

  assign expired = (count_q == LAST);

  // Count enabled cycles, restart on clear, stop at LAST instead of wrapping.
  // NOTE: state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !expired) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/wb_initiator.sv
// Wishbone classic single-transfer master. Accepts one command, runs one
// bus cycle, returns read data or a timeout error, then waits for the
// response to be consumed before taking the next command. Every output is
// a flop; nothing combinational reaches an output from an input.
module wb_initiator
  import wb_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          io_wbs_clk,
  input  logic          io_wbs_rst,
  wb_initiator_if.master bus
);

  state_t            state_q, state_d;
  wb_req_t           req_q, req_d;
  logic              cyc_q, cyc_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_dat_q, rsp_dat_d;
  logic              rsp_err_q, rsp_err_d;

  logic cnt_clear;
  logic cnt_enable;
  logic cnt_expired;

  wb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (io_wbs_clk),
    .rst     (io_wbs_rst),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .expired (cnt_expired)
  );

  // Next-state and next-output logic; everything holds unless a transition says otherwise.
  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    cyc_d       = cyc_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    cnt_clear   = 1'b0;
    cnt_enable  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          req_d.we  = bus.cmd_we;
          req_d.sel = bus.cmd_sel;
          req_d.adr = bus.cmd_adr;
          req_d.dat = bus.cmd_dat;
          cyc_d     = 1'b1;
          cnt_clear = 1'b1;
          state_d   = BUS;
        end
      end

      BUS: begin
        // Ack is checked before the timeout so a last-cycle ack still succeeds.
        if (bus.io_wbs_ack) begin
          rsp_dat_d   = req_q.we ? '0 : bus.io_wbs_datrd;
          rsp_err_d   = 1'b0;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (cnt_expired) begin
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_enable = 1'b1;
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Registered ready: high exactly while the FSM will sit in IDLE.
    cmd_ready_d = (state_d == IDLE);
  end

  // State and registered outputs; reset drops cyc/stb immediately.
  always_ff @(posedge io_wbs_clk or posedge io_wbs_rst) begin
    if (io_wbs_rst) begin
      state_q     <= IDLE;
      req_q       <= '0;
      cyc_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      cyc_q       <= cyc_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_dat      = rsp_dat_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.io_wbs_adr   = req_q.adr;
  assign bus.io_wbs_datwr = req_q.dat;
  assign bus.io_wbs_we    = req_q.we;
  assign bus.io_wbs_sel   = req_q.sel;
  assign bus.io_wbs_stb   = cyc_q;
  assign bus.io_wbs_cyc   = cyc_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Scoreboard bench for wb_initiator. Two instances share stimulus: dut_a with
// the default TIMEOUT and dut_b with TIMEOUT = 4; use_b selects which one the
// stimulus addresses and the monitors observe.
module tb_wb_initiator;
  import wb_initiator_pkg::*;

  typedef struct {
    logic [DATA_W-1:0] dat;
    logic              err;
    int                cyc_len;  // bus cycles with cyc high
    int                lat;      // accept edge to first edge sampling rsp_valid; -1 skips
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Stimulus
  logic              use_b;
  logic              cmd_valid, cmd_we, rsp_ready, ack;
  logic [SEL_W-1:0]  cmd_sel;
  logic [ADDR_W-1:0] cmd_adr;
  logic [DATA_W-1:0] cmd_dat, datrd;

  // Slave model configuration and expected bus contents
  int                slave_wait;
  bit                slave_never;
  bit                inject_ack;
  logic [DATA_W-1:0] slave_data;
  logic              cur_we;
  logic [SEL_W-1:0]  cur_sel;
  logic [ADDR_W-1:0] cur_adr;
  logic [DATA_W-1:0] cur_dat;

  // Bookkeeping
  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;
  int   acc_cycle;
  int   cyc_len;
  exp_t sb_q[$];

  wb_initiator_if if_a ();
  wb_initiator_if if_b ();

  wb_initiator #(.TIMEOUT(255)) dut_a (.io_wbs_clk(clk), .io_wbs_rst(rst), .bus(if_a));
  wb_initiator #(.TIMEOUT(4))   dut_b (.io_wbs_clk(clk), .io_wbs_rst(rst), .bus(if_b));

  assign if_a.cmd_valid    = cmd_valid && !use_b;
  assign if_b.cmd_valid    = cmd_valid && use_b;
  assign if_a.cmd_we       = cmd_we;
  assign if_b.cmd_we       = cmd_we;
  assign if_a.cmd_sel      = cmd_sel;
  assign if_b.cmd_sel      = cmd_sel;
  assign if_a.cmd_adr      = cmd_adr;
  assign if_b.cmd_adr      = cmd_adr;
  assign if_a.cmd_dat      = cmd_dat;
  assign if_b.cmd_dat      = cmd_dat;
  assign if_a.rsp_ready    = rsp_ready;
  assign if_b.rsp_ready    = rsp_ready;
  assign if_a.io_wbs_ack   = ack;
  assign if_b.io_wbs_ack   = ack;
  assign if_a.io_wbs_datrd = datrd;
  assign if_b.io_wbs_datrd = datrd;

  logic              obs_cmd_ready, obs_rsp_valid, obs_rsp_err, obs_cyc, obs_stb, obs_we;
  logic [SEL_W-1:0]  obs_sel;
  logic [ADDR_W-1:0] obs_adr;
  logic [DATA_W-1:0] obs_rsp_dat, obs_datwr;

  assign obs_cmd_ready = use_b ? if_b.cmd_ready    : if_a.cmd_ready;
  assign obs_rsp_valid = use_b ? if_b.rsp_valid    : if_a.rsp_valid;
  assign obs_rsp_err   = use_b ? if_b.rsp_err      : if_a.rsp_err;
  assign obs_rsp_dat   = use_b ? if_b.rsp_dat      : if_a.rsp_dat;
  assign obs_cyc       = use_b ? if_b.io_wbs_cyc   : if_a.io_wbs_cyc;
  assign obs_stb       = use_b ? if_b.io_wbs_stb   : if_a.io_wbs_stb;
  assign obs_we        = use_b ? if_b.io_wbs_we    : if_a.io_wbs_we;
  assign obs_sel       = use_b ? if_b.io_wbs_sel   : if_a.io_wbs_sel;
  assign obs_adr       = use_b ? if_b.io_wbs_adr   : if_a.io_wbs_adr;
  assign obs_datwr     = use_b ? if_b.io_wbs_datwr : if_a.io_wbs_datwr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic exp_t mk(input logic [31:0] dat, input logic err, input int len, input int lat);
    exp_t e;
    e.dat     = dat;
    e.err     = err;
    e.cyc_len = len;
    e.lat     = lat;
    return e;
  endfunction

  initial begin : cycle_counter
    forever begin
      @(posedge clk);
      cyc_no++;
    end
  end

  // Slave model: acks after slave_wait wait states and checks the bus
  // contents on every cycle that cyc is high.
  initial begin : slave_model
    int bus_cnt;
    bus_cnt = 0;
    ack     = 1'b0;
    datrd   = '0;
    forever begin
      @(negedge clk);
      #1;
      if (obs_cyc) begin
        bus_cnt++;
        cyc_len++;
        check("bus_stb",   32'(obs_stb), 32'd1);
        check("bus_we",    32'(obs_we), 32'(cur_we));
        check("bus_sel",   32'(obs_sel), 32'(cur_sel));
        check("bus_adr",   obs_adr, cur_adr);
        check("bus_datwr", obs_datwr, cur_dat);
        ack = !slave_never && (bus_cnt == slave_wait + 1);
      end else begin
        bus_cnt = 0;
        check("bus_stb_idle", 32'(obs_stb), 32'd0);
        ack = inject_ack;
      end
      datrd = slave_data;
    end
  end

  // Response monitor: compares every cycle rsp_valid is up against the head
  // of the scoreboard, pops on handshake.
  initial begin : rsp_monitor
    bit seen;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (obs_rsp_valid) begin
        if (sb_q.size() == 0) begin
          fail("rsp_unexpected");
        end else begin
          check("rsp_dat",       obs_rsp_dat, sb_q[0].dat);
          check("rsp_err",       32'(obs_rsp_err), 32'(sb_q[0].err));
          check("rsp_cmd_ready", 32'(obs_cmd_ready), 32'd0);
          check("rsp_cyc",       32'(obs_cyc), 32'd0);
          if (!seen) begin
            seen = 1'b1;
            check("cyc_len", 32'(cyc_len), 32'(sb_q[0].cyc_len));
            if (sb_q[0].lat >= 0)
              check("latency", 32'(cyc_no - acc_cycle + 1), 32'(sb_q[0].lat));
          end
          if (rsp_ready) begin
            void'(sb_q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                       input logic [31:0] dat, input bit push, input exp_t e);
    int budget;
    @(negedge clk);
    cur_we  = we;
    cur_sel = sel;
    cur_adr = adr;
    cur_dat = dat;
    cyc_len = 0;
    if (push) sb_q.push_back(e);
    cmd_we    = we;
    cmd_sel   = sel;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_valid = 1'b1;
    budget = 0;
    while (!obs_cmd_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!obs_cmd_ready) fail("cmd_accept_timeout");
    acc_cycle = cyc_no + 1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("accept_cyc",       32'(obs_cyc), 32'd1);
    check("accept_cmd_ready", 32'(obs_cmd_ready), 32'd0);
  endtask

  task automatic wait_done(input string name);
    int budget;
    budget = 0;
    while ((sb_q.size() != 0 || obs_cyc) && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 400) begin
      fail({name, "_done_timeout"});
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_rsp(input string name);
    int budget;
    budget = 0;
    while (!obs_rsp_valid && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    if (!obs_rsp_valid) fail({name, "_rsp_timeout"});
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "simulation did not finish");
  end

  initial begin : stimulus
    use_b = 1'b0;  cmd_valid = 1'b0; cmd_we = 1'b0; cmd_sel = '0;
    cmd_adr = '0;  cmd_dat = '0;     rsp_ready = 1'b1;
    slave_wait = 0; slave_never = 1'b0; inject_ack = 1'b0; slave_data = '0;
    cur_we = 1'b0; cur_sel = '0; cur_adr = '0; cur_dat = '0;
    cyc_len = 0;   acc_cycle = 0;

    // Reset takes effect before any clock edge.
    #1 rst = 1'b1;
    #2;
    check("rst_cmd_ready", 32'(if_a.cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(if_a.rsp_valid), 32'd0);
    check("rst_rsp_dat",   if_a.rsp_dat, 32'd0);
    check("rst_rsp_err",   32'(if_a.rsp_err), 32'd0);
    check("rst_cyc",       32'(if_a.io_wbs_cyc), 32'd0);
    check("rst_stb",       32'(if_a.io_wbs_stb), 32'd0);
    check("rst_we",        32'(if_a.io_wbs_we), 32'd0);
    check("rst_sel",       32'(if_a.io_wbs_sel), 32'd0);
    check("rst_adr",       if_a.io_wbs_adr, 32'd0);
    check("rst_datwr",     if_a.io_wbs_datwr, 32'd0);
    check("rst_b_cmd_ready", 32'(if_b.cmd_ready), 32'd1);
    check("rst_b_cyc",       32'(if_b.io_wbs_cyc), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Write, immediate ack: rsp_dat must be 0 although datrd carries data.
    slave_wait = 0;
    slave_data = 32'hCAFE_F00D;
    issue(1'b1, 4'hF, 32'h3000_0004, 32'hDEAD_BEEF, 1'b1, mk(32'h0, 1'b0, 1, 2));
    wait_done("wr_imm");

    // Read, five wait states.
    slave_wait = 5;
    slave_data = 32'h1234_5678;
    issue(1'b0, 4'hF, 32'h3000_0010, 32'h0, 1'b1, mk(32'h1234_5678, 1'b0, 6, 7));
    wait_done("rd_wait5");

    // Timeout on dut_b (TIMEOUT = 4); an ack during RESP must not change it.
    use_b       = 1'b1;
    slave_never = 1'b1;
    rsp_ready   = 1'b0;
    issue(1'b0, 4'h3, 32'h3000_0020, 32'h1111_2222, 1'b1, mk(32'h0, 1'b1, 4, 5));
    wait_rsp("timeout");
    inject_ack = 1'b1;
    repeat (3) @(negedge clk);
    inject_ack = 1'b0;
    rsp_ready  = 1'b1;
    wait_done("timeout");

    // Stray ack while idle.
    inject_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #2;
      check("stray_ack_cyc",       32'(obs_cyc), 32'd0);
      check("stray_ack_rsp_valid", 32'(obs_rsp_valid), 32'd0);
    end
    inject_ack  = 1'b0;
    slave_never = 1'b0;

    // Ack in the fourth (timeout) bus cycle wins over the timeout.
    slave_wait = 3;
    slave_data = 32'hA5A5_5A5A;
    issue(1'b0, 4'hF, 32'h3000_0024, 32'h0, 1'b1, mk(32'hA5A5_5A5A, 1'b0, 4, 5));
    wait_done("ack_on_timeout");

    // Backpressure on dut_a with a second command waiting behind it.
    use_b      = 1'b0;
    slave_wait = 1;
    slave_data = 32'h0BAD_F00D;
    rsp_ready  = 1'b0;
    issue(1'b0, 4'h5, 32'h3000_0008, 32'h0, 1'b1, mk(32'h0BAD_F00D, 1'b0, 2, 3));
    wait_rsp("backpressure");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin
        slave_wait = 0;
        cur_we  = 1'b1;
        cur_sel = 4'hC;
        cur_adr = 32'h3000_000C;
        cur_dat = 32'h5555_AAAA;
        cyc_len = 0;
        sb_q.push_back(mk(32'h0, 1'b0, 1, 2));
        cmd_we    = 1'b1;
        cmd_sel   = 4'hC;
        cmd_adr   = 32'h3000_000C;
        cmd_dat   = 32'h5555_AAAA;
        cmd_valid = 1'b1;
      end
      #2;
      check("bp_cmd_ready", 32'(obs_cmd_ready), 32'd0);
      check("bp_cyc",       32'(obs_cyc), 32'd0);
      check("bp_rsp_valid", 32'(obs_rsp_valid), 32'd1);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    #2;
    check("bp_release_cmd_ready", 32'(obs_cmd_ready), 32'd1);
    check("bp_release_rsp_valid", 32'(obs_rsp_valid), 32'd0);
    acc_cycle = cyc_no + 1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("bp_second_accept_cyc", 32'(obs_cyc), 32'd1);
    wait_done("backpressure");

    // Reset in the second bus cycle of a read: no response may appear.
    slave_never = 1'b1;
    issue(1'b0, 4'hF, 32'h3000_0030, 32'h0, 1'b0, mk(32'h0, 1'b0, 0, -1));
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midbus_rst_cyc", 32'(obs_cyc), 32'd0);
    check("midbus_rst_stb", 32'(obs_stb), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    slave_never = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #2;
      check("post_rst_rsp_valid", 32'(obs_rsp_valid), 32'd0);
      check("post_rst_cmd_ready", 32'(obs_cmd_ready), 32'd1);
    end
    slave_wait = 2;
    slave_data = 32'h600D_CAFE;
    issue(1'b0, 4'hF, 32'h3000_0014, 32'h0, 1'b1, mk(32'h600D_CAFE, 1'b0, 3, 4));
    wait_done("post_rst_read");

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_initiator.md
# wb_initiator

Wishbone classic single-transfer master: the initiator counterpart to the peripheral-side slaves (wfg_top, wb_memory) and to wb_mux. It converts a simple valid/ready command stream into one Wishbone read or write cycle at a time, returns the read data or a timeout error on a valid/ready response stream, and drives any io_wbs_* slave port directly. It serves on-chip agents such as a logic-analyzer-driven bus bridge or a future sequencer that must reach wfg_top and wb_memory registers without the management SoC.

## Interface
Parameters:
- TIMEOUT, 255, maximum bus cycles waited for io_wbs_ack; legal range 1..65535.

Ports:
- io_wbs_clk  in  1  single clock; all logic is on the rising edge.
- io_wbs_rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_sel  in  4  byte selects.
- cmd_adr  in  32  byte address.
- cmd_dat  in  32  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_dat  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  1 = timeout, no ack received.
- io_wbs_adr  out  32  bus address.
- io_wbs_datwr  out  32  bus write data.
- io_wbs_datrd  in  32  bus read data.
- io_wbs_we  out  1  bus write enable.
- io_wbs_sel  out  4  bus byte selects.
- io_wbs_stb  out  1  strobe.
- io_wbs_cyc  out  1  cycle.
- io_wbs_ack  in  1  slave acknowledge.

## Operation
- FSM states are IDLE, BUS and RESP.
- **IDLE**
  - cmd_ready = 1. All other outputs hold their last values, except that cyc and stb are 0.
  - On a command handshake: latch we, sel, adr and dat onto the io_wbs_* outputs, set cyc = stb = 1, clear the timeout counter, and go to BUS.
- **BUS**
  - cmd_ready = 0. cyc, stb, adr, datwr, we and sel are held stable.
  - If io_wbs_ack is sampled high:
    - rsp_dat = we ? 0 : io_wbs_datrd, and rsp_err = 0.
    - cyc = stb = 0, rsp_valid = 1, go to RESP.
  - Else, if counter == TIMEOUT-1:
    - rsp_dat = 0, rsp_err = 1.
    - cyc = stb = 0, rsp_valid = 1, go to RESP.
  - Else, counter increments.
  - If ack arrives in the same cycle as the timeout, ack wins and rsp_err = 0.
- **RESP**
  - rsp_valid = 1, and rsp_dat and rsp_err are held stable until rsp_ready.
  - On the response handshake: rsp_valid = 0, go to IDLE.
- io_wbs_ack is ignored in IDLE and RESP. A stray or late ack has no effect.
- Counter width is $clog2(TIMEOUT). It saturates and never wraps.
- Exactly one outstanding transaction. No pipelining, no bursts, no retries.

## Timing
- **Reset values (asynchronous, immediate):** state IDLE, cmd_ready 1, rsp_valid 0, rsp_dat 0, rsp_err 0, io_wbs_cyc 0, io_wbs_stb 0, io_wbs_we 0, io_wbs_sel 0, io_wbs_adr 0, io_wbs_datwr 0, counter 0.
- **Reset mid-transaction:** cyc and stb drop in the same cycle and the transaction is discarded. No response is produced.
- **Command accept:** command accepted at edge N, so cyc/stb are high from N+1.
- **Ack:** ack sampled at edge M gives cyc/stb low and rsp_valid high from M+1.
  - Minimum latency (slave acks in the first bus cycle): command edge to rsp_valid is 2 cycles.
- **Timeout:** cyc/stb are high for exactly TIMEOUT cycles, then rsp_valid is asserted in the following cycle.
- **Back-to-back:** response handshake at edge R makes cmd_ready 1 from R+1. The minimum issue interval is 3 cycles.
- All outputs are registered. There are no combinational paths from any input to any output.

## Structure
- Package wb_initiator_pkg holds:
  - the state enum (IDLE, BUS, RESP);
  - Wishbone width constants (ADDR_W = 32, DATA_W = 32, SEL_W = 4), shared with wb_mux and wb_memory.
- Sub-module wb_timeout_counter is parameterized by TIMEOUT, with inputs clear and enable and output expired. It is reusable by wb_memory.

## Test plan
- **Write with immediate ack:** cmd write, adr 0x3000_0004, dat 0xDEAD_BEEF, sel 0xF; slave acks in cycle 1 -> io_wbs_we = 1 and datwr = 0xDEAD_BEEF while cyc is high; rsp_valid 2 cycles after accept, rsp_err 0, rsp_dat 0.
- **Read with 5-wait-state slave:** returns 0x1234_5678 -> cyc high for 6 cycles, rsp_dat = 0x1234_5678, rsp_err 0.
- **Timeout:** TIMEOUT = 4 and the slave never acks -> cyc high exactly 4 cycles, then rsp_err 1 and rsp_dat 0. An ack injected afterwards is ignored.
- **Ack on the timeout cycle:** with TIMEOUT = 4, ack arrives in bus cycle 4 -> rsp_err 0 and data captured.
- **Response backpressure:** rsp_ready held low for 10 cycles -> rsp_valid, rsp_dat and rsp_err stable, cmd_ready 0, no new bus cycle; cmd_ready 1 the cycle after the handshake.
- **Reset mid-BUS:** io_wbs_rst pulsed during cycle 2 of a read -> cyc/stb 0 the same cycle, no rsp_valid, and the next command completes normally.
